// File: rtl/stash_pkg.sv
// Shared constants and beat-0 decode for the stash op5 sync stream.
// Optional statistics are controlled by STASH_SYNC_STATS_EN (see stash_sync_rx).
package stash_pkg;

    localparam logic [7:0]  SYNC_OPCODE   = 8'h05;
    localparam int          OPC_LSB       = 248;
    localparam int          SUBOP_LSB     = 240;
    localparam int          KEY_LSB       = 208;
    localparam int          SLOT_LSB      = 200;
    localparam int          PKT_KEY_W     = 32;
    localparam logic [31:0] KEEP_REQ_MASK = 32'hFE00_0000;

    typedef enum logic [7:0] {
        SUBOP_INSERT = 8'h01,
        SUBOP_DELETE = 8'h02,
        SUBOP_FLUSH  = 8'h03
    } subop_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAIN,
        S_APPLY
    } rx_state_e;

    typedef struct packed {
        logic [7:0]           opcode;
        logic [7:0]           subop;
        logic [PKT_KEY_W-1:0] key;
        logic [7:0]           slot;
    } beat0_t;

    function automatic beat0_t decode_beat0(input logic [255:0] d);
        beat0_t h;
        h.opcode = d[OPC_LSB   +: 8];
        h.subop  = d[SUBOP_LSB +: 8];
        h.key    = d[KEY_LSB   +: PKT_KEY_W];
        h.slot   = d[SLOT_LSB  +: 8];
        return h;
    endfunction

endpackage

// File: rtl/stash_sync_cam.sv
// Mirror table of the stash key/slot map: valid/key registers, one update port,
// parallel match with a registered lookup result and registered occupancy.
module stash_sync_cam #(
    parameter int DEPTH  = 16,
    parameter int KEY_W  = 32,
    parameter int SLOT_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ins_en,
    input  logic              del_en,
    input  logic              flush_en,
    input  logic [KEY_W-1:0]  op_key,
    input  logic [SLOT_W-1:0] op_slot,
    output logic              del_hit,
    input  logic [KEY_W-1:0]  lkp_key,
    input  logic              lkp_valid,
    output logic              lkp_valid_q,
    output logic              lkp_hit,
    output logic [SLOT_W-1:0] lkp_slot,
    output logic [SLOT_W:0]   occupancy
);

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [KEY_W-1:0] key_q [DEPTH];
    logic [DEPTH-1:0] match;
    logic [SLOT_W-1:0] match_slot;
    logic [SLOT_W:0]   occ_d;

    assign del_hit = valid_q[op_slot] && (key_q[op_slot] == op_key);

    // An INSERT also drops any other slot holding the same key, keeping keys unique.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        valid_d = valid_q;
        if (flush_en) begin
            valid_d = '0;
        end else if (ins_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (valid_q[i] && (key_q[i] == op_key)) valid_d[i] = 1'b0;
            end
            valid_d[op_slot] = 1'b1;
        end else if (del_en) begin
            valid_d[op_slot] = 1'b0;
        end
    end

    always_comb begin
        // NOTE: blocking assignments here model combinational accumulation; registers below use <= only.
        occ_d      = '0;
        match_slot = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match[i] = valid_q[i] && (key_q[i] == lkp_key);
            occ_d    = occ_d + (SLOT_W+1)'(valid_d[i]);
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (match[i]) match_slot = SLOT_W'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= '0;
            occupancy   <= '0;
            lkp_valid_q <= 1'b0;
            lkp_hit     <= 1'b0;
            lkp_slot    <= '0;
        end else begin
            valid_q     <= valid_d;
            occupancy   <= occ_d;
            lkp_valid_q <= lkp_valid;
            lkp_hit     <= lkp_valid && (|match);
            lkp_slot    <= (lkp_valid && (|match)) ? match_slot : '0;
        end
    end

    // NOTE: key storage is qualified by valid_q, so it needs no reset.
    always_ff @(posedge clk) begin
        if (ins_en) key_q[op_slot] <= op_key;
    end

endmodule

// File: rtl/stash_sync_rx.sv
// Receiver for the stash op5 sync stream: packet FSM, beat-0 decode, mirror table and lookup.
// Define STASH_SYNC_STATS_EN to build the saturating INSERT/DELETE/error counters.
module stash_sync_rx
    import stash_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int KEY_W  = 32,
    parameter int SLOT_W = $clog2(DEPTH),
    parameter int CNT_W  = 16
) (
    input  logic              axis_aclk,
    input  logic              axis_reset,
    input  logic [255:0]      i_op5_sync_tdata,
    input  logic [31:0]       i_op5_sync_tkeep,
    input  logic [127:0]      i_op5_sync_tuser,
    input  logic              i_op5_sync_tvalid,
    output logic              o_op5_sync_tready,
    input  logic              i_op5_sync_tlast,
    input  logic [KEY_W-1:0]  i_lkp_key,
    input  logic              i_lkp_valid,
    output logic              o_lkp_valid,
    output logic              o_lkp_hit,
    output logic [SLOT_W-1:0] o_lkp_slot,
    output logic [SLOT_W:0]   o_occupancy,
    output logic [CNT_W-1:0]  o_ins_cnt,
    output logic [CNT_W-1:0]  o_del_cnt,
    output logic [CNT_W-1:0]  o_err_cnt
);

    rx_state_e        state;
    logic             tready_q;
    logic             hs;
    beat0_t           hdr;
    logic [7:0]       cap_opcode;
    logic [7:0]       cap_subop;
    logic [KEY_W-1:0] cap_key;
    logic [7:0]       cap_slot;
    logic             cap_keep_ok;
    logic             slot_ok;
    logic             del_hit;
    logic             ins_en, del_en, flush_en, pkt_err;
    logic             unused_ok;

    assign unused_ok = ^{i_op5_sync_tuser, i_op5_sync_tdata[SLOT_LSB-1:0], i_op5_sync_tkeep[24:0]};

    // tready_q resets to 1 so the port opens on the first cycle after reset.
    assign o_op5_sync_tready = tready_q && !axis_reset;
    assign hs  = i_op5_sync_tvalid && o_op5_sync_tready;
    assign hdr = decode_beat0(i_op5_sync_tdata);

    always_ff @(posedge axis_aclk) begin
        if (axis_reset) begin
            state       <= S_IDLE;
            tready_q    <= 1'b1;
            cap_opcode  <= '0;
            cap_subop   <= '0;
            cap_key     <= '0;
            cap_slot    <= '0;
            cap_keep_ok <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (hs) begin
                    cap_opcode  <= hdr.opcode;
                    cap_subop   <= hdr.subop;
                    cap_key     <= KEY_W'(hdr.key);
                    cap_slot    <= hdr.slot;
                    cap_keep_ok <= (i_op5_sync_tkeep & KEEP_REQ_MASK) == KEEP_REQ_MASK;
                    state       <= i_op5_sync_tlast ? S_APPLY : S_DRAIN;
                    tready_q    <= !i_op5_sync_tlast;
                end
                S_DRAIN: if (hs && i_op5_sync_tlast) begin
                    state    <= S_APPLY;
                    tready_q <= 1'b0;
                end
                default: begin
                    state    <= S_IDLE;
                    tready_q <= 1'b1;
                end
            endcase
        end
    end

    assign slot_ok = {1'b0, cap_slot} < 9'(DEPTH);

    always_comb begin
        ins_en   = 1'b0;
        del_en   = 1'b0;
        flush_en = 1'b0;
        pkt_err  = 1'b0;
        if (state == S_APPLY) begin
            if ((cap_opcode != SYNC_OPCODE) || !cap_keep_ok) begin
                pkt_err = 1'b1;
            end else begin
                case (cap_subop)
                    SUBOP_INSERT: if (slot_ok) ins_en = 1'b1; else pkt_err = 1'b1;
                    SUBOP_DELETE: if (slot_ok && del_hit) del_en = 1'b1; else pkt_err = 1'b1;
                    SUBOP_FLUSH:  flush_en = 1'b1;
                    default:      pkt_err = 1'b1;
                endcase
            end
        end
    end

    stash_sync_cam #(
        .DEPTH  (DEPTH),
        .KEY_W  (KEY_W),
        .SLOT_W (SLOT_W)
    ) u_cam (
        .clk         (axis_aclk),
        .rst         (axis_reset),
        .ins_en      (ins_en),
        .del_en      (del_en),
        .flush_en    (flush_en),
        .op_key      (cap_key),
        .op_slot     (cap_slot[SLOT_W-1:0]),
        .del_hit     (del_hit),
        .lkp_key     (i_lkp_key),
        .lkp_valid   (i_lkp_valid),
        .lkp_valid_q (o_lkp_valid),
        .lkp_hit     (o_lkp_hit),
        .lkp_slot    (o_lkp_slot),
        .occupancy   (o_occupancy)
    );

`ifdef STASH_SYNC_STATS_EN
    always_ff @(posedge axis_aclk) begin
        if (axis_reset) begin
            o_ins_cnt <= '0;
            o_del_cnt <= '0;
            o_err_cnt <= '0;
        end else begin
            if (ins_en  && (o_ins_cnt != '1)) o_ins_cnt <= o_ins_cnt + CNT_W'(1);
            if (del_en  && (o_del_cnt != '1)) o_del_cnt <= o_del_cnt + CNT_W'(1);
            if (pkt_err && (o_err_cnt != '1)) o_err_cnt <= o_err_cnt + CNT_W'(1);
        end
    end
`else
    assign o_ins_cnt = '0;
    assign o_del_cnt = '0;
    assign o_err_cnt = '0;
`endif

endmodule

// File: tb/tb_stash_sync_rx.sv
// Self-checking bench for stash_sync_rx: table-driven single-beat packets, hand-written
// multi-beat / flush / reset sequences, and a scoreboard queue for lookup results.
module tb_stash_sync_rx;

`ifdef STASH_SYNC_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic         axis_aclk = 1'b0;
    logic         axis_reset;
    logic [255:0] tdata;
    logic [31:0]  tkeep;
    logic [127:0] tuser;
    logic         tvalid, tlast, tready;
    logic [31:0]  lkp_key;
    logic         lkp_valid_i, lkp_valid_o, lkp_hit;
    logic [3:0]   lkp_slot;
    logic [4:0]   occupancy;
    logic [15:0]  ins_cnt, del_cnt, err_cnt;

    always #5 axis_aclk = ~axis_aclk;

    stash_sync_rx dut (
        .axis_aclk         (axis_aclk),
        .axis_reset        (axis_reset),
        .i_op5_sync_tdata  (tdata),
        .i_op5_sync_tkeep  (tkeep),
        .i_op5_sync_tuser  (tuser),
        .i_op5_sync_tvalid (tvalid),
        .o_op5_sync_tready (tready),
        .i_op5_sync_tlast  (tlast),
        .i_lkp_key         (lkp_key),
        .i_lkp_valid       (lkp_valid_i),
        .o_lkp_valid       (lkp_valid_o),
        .o_lkp_hit         (lkp_hit),
        .o_lkp_slot        (lkp_slot),
        .o_occupancy       (occupancy),
        .o_ins_cnt         (ins_cnt),
        .o_del_cnt         (del_cnt),
        .o_err_cnt         (err_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit mon_en   = 1'b0;

    typedef struct {
        int         due;
        logic       hit;
        logic [3:0] slot;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic [7:0]  opc;
        logic [7:0]  subop;
        logic [31:0] key;
        logic [7:0]  slot;
        logic [31:0] keep;
        logic [31:0] lkey;
        logic        exp_hit;
        logic [3:0]  exp_slot;
        logic [4:0]  exp_occ;
        int          exp_ins;
        int          exp_del;
        int          exp_err;
    } vec_t;
    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] cnt_exp(input int v);
        return STATS ? 16'(v) : 16'd0;
    endfunction

    always @(posedge axis_aclk) cyc <= cyc + 1;

    // Lookup scoreboard: a result is due exactly one cycle after its request.
    always @(negedge axis_aclk) begin
        if (mon_en) begin
            if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
                exp_t e;
                e = sb_q.pop_front();
                check("lkp_valid", 64'(lkp_valid_o), 64'd1);
                check("lkp_hit",   64'(lkp_hit),     64'(e.hit));
                check("lkp_slot",  64'(lkp_slot),    64'(e.slot));
            end else begin
                check("lkp_valid_idle", 64'(lkp_valid_o), 64'd0);
            end
        end
    end

    function automatic logic [255:0] make_beat(input logic [7:0] opc, input logic [7:0] subop,
                                               input logic [31:0] key, input logic [7:0] slot);
        return {opc, subop, key, slot, 200'(64'hC0FF_EE00_1234_5678)};
    endfunction

    // Drives one beat and returns how many cycles it waited for tready.
    task automatic send_beat(input logic [255:0] d, input logic [31:0] k, input logic last,
                             output int waits);
        logic rdy;
        waits  = 0;
        tdata  = d;
        tkeep  = k;
        tlast  = last;
        tuser  = {4{$urandom}};
        tvalid = 1'b1;
        forever begin
            rdy = tready;
            @(posedge axis_aclk);
            #1;
            if (rdy) break;
            waits++;
            if (waits > 20) begin
                check("beat_accept_timeout", 64'd1, 64'd0);
                break;
            end
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic send_pkt1(input logic [7:0] opc, input logic [7:0] subop, input logic [31:0] key,
                             input logic [7:0] slot, input logic [31:0] keep);
        int w;
        send_beat(make_beat(opc, subop, key, slot), keep, 1'b1, w);
    endtask

    task automatic lookup(input logic [31:0] key, input logic hit, input logic [3:0] slot);
        exp_t e;
        e.due  = cyc + 1;
        e.hit  = hit;
        e.slot = slot;
        sb_q.push_back(e);
        lkp_key     = key;
        lkp_valid_i = 1'b1;
        @(posedge axis_aclk);
        #1;
        lkp_valid_i = 1'b0;
    endtask

    task automatic check_stats(input string tag, input logic [4:0] occ, input int ins, input int del, input int err);
        check({tag, "_occ"}, 64'(occupancy), 64'(occ));
        check({tag, "_ins"}, 64'(ins_cnt),   64'(cnt_exp(ins)));
        check({tag, "_del"}, 64'(del_cnt),   64'(cnt_exp(del)));
        check({tag, "_err"}, 64'(err_cnt),   64'(cnt_exp(err)));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        vecs[0]  = '{8'h05, 8'h01, 32'hA5A5_0001, 8'd3,  32'hFFFF_FFFF, 32'hA5A5_0001, 1'b1, 4'd3,  5'd1, 1, 0, 0};
        vecs[1]  = '{8'h05, 8'h01, 32'hA5A5_0001, 8'd7,  32'hFFFF_FFFF, 32'hA5A5_0001, 1'b1, 4'd7,  5'd1, 2, 0, 0};
        vecs[2]  = '{8'h05, 8'h02, 32'hDEAD_BEEF, 8'd7,  32'hFFFF_FFFF, 32'hA5A5_0001, 1'b1, 4'd7,  5'd1, 2, 0, 1};
        vecs[3]  = '{8'h05, 8'h02, 32'hA5A5_0001, 8'd7,  32'hFFFF_FFFF, 32'hA5A5_0001, 1'b0, 4'd0,  5'd0, 2, 1, 1};
        vecs[4]  = '{8'h05, 8'h01, 32'h1111_0000, 8'd0,  32'h7FFF_FFFF, 32'h1111_0000, 1'b0, 4'd0,  5'd0, 2, 1, 2};
        vecs[5]  = '{8'h06, 8'h01, 32'h1111_0000, 8'd0,  32'hFFFF_FFFF, 32'h1111_0000, 1'b0, 4'd0,  5'd0, 2, 1, 3};
        vecs[6]  = '{8'h05, 8'h04, 32'h1111_0000, 8'd0,  32'hFFFF_FFFF, 32'h1111_0000, 1'b0, 4'd0,  5'd0, 2, 1, 4};
        vecs[7]  = '{8'h05, 8'h01, 32'h2222_0002, 8'd15, 32'hFFFF_FFFF, 32'h2222_0002, 1'b1, 4'd15, 5'd1, 3, 1, 4};
        vecs[8]  = '{8'h05, 8'h01, 32'h3333_0003, 8'd15, 32'hFFFF_FFFF, 32'h3333_0003, 1'b1, 4'd15, 5'd1, 4, 1, 4};
        vecs[9]  = '{8'h05, 8'h01, 32'h2222_0002, 8'd16, 32'hFFFF_FFFF, 32'h2222_0002, 1'b0, 4'd0,  5'd1, 4, 1, 5};
        vecs[10] = '{8'h05, 8'h02, 32'h3333_0003, 8'd20, 32'hFFFF_FFFF, 32'h3333_0003, 1'b1, 4'd15, 5'd1, 4, 1, 6};
        vecs[11] = '{8'h05, 8'h01, 32'h4444_0004, 8'd0,  32'hFE00_0000, 32'h4444_0004, 1'b1, 4'd0,  5'd2, 5, 1, 6};

        axis_reset  = 1'b1;
        tvalid      = 1'b0;
        tlast       = 1'b0;
        tdata       = '0;
        tkeep       = '0;
        tuser       = '0;
        lkp_key     = '0;
        lkp_valid_i = 1'b0;
        repeat (3) @(posedge axis_aclk);
        #1;
        check("rst_tready", 64'(tready), 64'd0);
        check("rst_lkp_valid", 64'(lkp_valid_o), 64'd0);
        check_stats("rst", 5'd0, 0, 0, 0);
        axis_reset = 1'b0;
        #1;
        check("post_rst_tready", 64'(tready), 64'd1);
        mon_en = 1'b1;

        for (int i = 0; i < 12; i++) begin
            send_pkt1(vecs[i].opc, vecs[i].subop, vecs[i].key, vecs[i].slot, vecs[i].keep);
            @(posedge axis_aclk);
            #1;
            check_stats($sformatf("vec%0d", i), vecs[i].exp_occ, vecs[i].exp_ins, vecs[i].exp_del, vecs[i].exp_err);
            lookup(vecs[i].lkey, vecs[i].exp_hit, vecs[i].exp_slot);
        end

        // 3-beat INSERT with tvalid gaps; beat 1 mimics another INSERT and must be discarded.
        send_beat(make_beat(8'h05, 8'h01, 32'h5555_0005, 8'd5), 32'hFFFF_FFFF, 1'b0, w);
        check("mb_beat0_wait", 64'(w), 64'd0);
        check("mb_gap0_tready", 64'(tready), 64'd1);
        @(posedge axis_aclk);
        #1;
        send_beat(make_beat(8'h05, 8'h01, 32'h6666_0006, 8'd6), 32'hFFFF_FFFF, 1'b0, w);
        check("mb_beat1_wait", 64'(w), 64'd0);
        @(posedge axis_aclk);
        #1;
        send_beat('0, 32'h0000_00FF, 1'b1, w);
        check("mb_beat2_wait", 64'(w), 64'd0);
        check("mb_apply_tready", 64'(tready), 64'd0);
        @(posedge axis_aclk);
        #1;
        check("mb_idle_tready", 64'(tready), 64'd1);
        check_stats("mb", 5'd3, 6, 1, 6);
        lookup(32'h5555_0005, 1'b1, 4'd5);
        lookup(32'h6666_0006, 1'b0, 4'd0);

        // Fill every slot, then FLUSH with a lookup issued in the APPLY cycle.
        for (int i = 0; i < 16; i++) begin
            send_pkt1(8'h05, 8'h01, 32'h1000_0000 + 32'(i), 8'(i), 32'hFFFF_FFFF);
        end
        @(posedge axis_aclk);
        #1;
        check_stats("fill", 5'd16, 22, 1, 6);
        lookup(32'h1000_000F, 1'b1, 4'd15);
        send_pkt1(8'h05, 8'h03, 32'h0, 8'd0, 32'hFFFF_FFFF);
        lookup(32'h1000_0003, 1'b1, 4'd3);
        lookup(32'h1000_0003, 1'b0, 4'd0);
        check_stats("flush", 5'd0, 22, 1, 6);

        // Reset while draining a 4-beat packet.
        send_pkt1(8'h05, 8'h01, 32'h7777_0007, 8'd2, 32'hFFFF_FFFF);
        @(posedge axis_aclk);
        #1;
        check("pre_rst_occ", 64'(occupancy), 64'd1);
        send_beat(make_beat(8'h05, 8'h01, 32'h8888_0008, 8'd8), 32'hFFFF_FFFF, 1'b0, w);
        send_beat('0, 32'hFFFF_FFFF, 1'b0, w);
        repeat (2) @(negedge axis_aclk);
        #1;
        axis_reset = 1'b1;
        #1;
        check("mid_rst_tready", 64'(tready), 64'd0);
        repeat (2) @(posedge axis_aclk);
        #1;
        check("mid_rst_tready2", 64'(tready), 64'd0);
        axis_reset = 1'b0;
        #1;
        check("after_rst_tready", 64'(tready), 64'd1);
        check_stats("after_rst", 5'd0, 0, 0, 0);
        lookup(32'h7777_0007, 1'b0, 4'd0);
        lookup(32'h8888_0008, 1'b0, 4'd0);
        send_pkt1(8'h05, 8'h01, 32'h9999_0009, 8'd16, 32'hFFFF_FFFF);
        @(posedge axis_aclk);
        #1;
        check_stats("slot16", 5'd0, 0, 0, 1);
        lookup(32'h9999_0009, 1'b0, 4'd0);

        repeat (3) @(posedge axis_aclk);
        #1;
        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
